count_seq_checker: RTL and testbench

COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

---
 rtl/count_seq_checker.sv | 173 +++++++++++++++++
 tb/tb_count_seq_checker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
// ---------------------------------------------------------------------------
// count_seq_checker
//   Monitors a free-running counter (0,1,..,MAX_VAL,0,..) delivered by an
//   upstream stage. The checker locks after LOCK_COUNT consecutive correct
//   transitions. While locked it flags each wrong transition and counts it.
//   It raises an alarm after ERR_LIMIT wrong transitions in a row.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   reset        synchronous, active-high reset
//   cnt_in       count value from the upstream stage
//   cnt_valid    cnt_in is sampled this cycle when high
//   clr_stats    synchronous clear of statistics and state (beats a sample)
//   seq_err      one-cycle pulse after a mismatch seen while LOCKED
//   locked       high while in LOCKED
//   alarm        high while in ALARM
//   expected     next legal value after the last stored sample (0 if none)
//   err_count    saturating mismatch count (LOCKED only)
//   period_count wrapping count of MAX_VAL->0 transitions while LOCKED
// ---------------------------------------------------------------------------
module count_seq_checker #(
    parameter int MAX_VAL    = 4,
    parameter int LOCK_COUNT = 2,
    parameter int ERR_LIMIT  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  cnt_in,
    input  logic        cnt_valid,
    input  logic        clr_stats,
    output logic        seq_err,
    output logic        locked,
    output logic        alarm,
    output logic [2:0]  expected,
    output logic [7:0]  err_count,
    output logic [15:0] period_count
);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_ALARM  = 2'd2;

    localparam logic [2:0] MAX_V  = 3'(MAX_VAL);
    localparam logic [7:0] LOCK_N = 8'(LOCK_COUNT);
    localparam logic [7:0] ERR_N  = 8'(ERR_LIMIT);

    logic [1:0]  state_q, state_d;
    logic [2:0]  prev_q, prev_d;
    logic        prev_vld_q, prev_vld_d;
    logic [7:0]  good_run_q, good_run_d;
    logic [7:0]  bad_run_q, bad_run_d;
    logic [7:0]  err_count_q, err_count_d;
    logic [15:0] period_count_q, period_count_d;
    logic        seq_err_q, seq_err_d;
    logic [2:0]  expected_q, expected_d;

    logic        in_legal;
    logic        prev_legal;
    logic [2:0]  next_of_prev;
    logic [2:0]  next_of_in;
    logic        is_match;
    logic        is_wrap;

    always_comb begin
        in_legal     = (cnt_in <= MAX_V);
        prev_legal   = (prev_q <= MAX_V);
        next_of_prev = (prev_q == MAX_V) ? 3'd0 : prev_q + 3'd1;
        next_of_in   = (cnt_in == MAX_V) ? 3'd0 : cnt_in + 3'd1;
        // A stored out-of-range value has no legal successor, so nothing
        // following it can match.
        is_match     = prev_legal && in_legal && (cnt_in == next_of_prev);
        is_wrap      = (prev_q == MAX_V) && (cnt_in == 3'd0);
    end

    always_comb begin
        state_d        = state_q;
        prev_d         = prev_q;
        prev_vld_d     = prev_vld_q;
        good_run_d     = good_run_q;
        bad_run_d      = bad_run_q;
        err_count_d    = err_count_q;
        period_count_d = period_count_q;
        expected_d     = expected_q;
        seq_err_d      = 1'b0;

        if (clr_stats) begin
            // Any sample in this cycle is dropped. prev keeps its value,
            // but with prev_vld low it is never used.
            state_d        = ST_HUNT;
            prev_vld_d     = 1'b0;
            good_run_d     = 8'd0;
            bad_run_d      = 8'd0;
            err_count_d    = 8'd0;
            period_count_d = 16'd0;
            expected_d     = 3'd0;
        end else if (cnt_valid) begin
            prev_d     = cnt_in;
            prev_vld_d = 1'b1;
            expected_d = in_legal ? next_of_in : 3'd0;

            if (prev_vld_q) begin
                case (state_q)
                    ST_HUNT: begin
                        if (is_match) begin
                            if (good_run_q + 8'd1 >= LOCK_N) begin
                                state_d    = ST_LOCKED;
                                good_run_d = 8'd0;
                                bad_run_d  = 8'd0;
                            end else begin
                                good_run_d = good_run_q + 8'd1;
                            end
                        end else begin
                            good_run_d = 8'd0;
                        end
                    end
                    ST_LOCKED: begin
                        if (is_match) begin
                            bad_run_d = 8'd0;
                            if (is_wrap) begin
                                period_count_d = period_count_q + 16'd1;
                            end
                        end else begin
                            seq_err_d = 1'b1;
                            if (err_count_q != 8'hFF) begin
                                err_count_d = err_count_q + 8'd1;
                            end
                            bad_run_d = bad_run_q + 8'd1;
                            if (bad_run_q + 8'd1 >= ERR_N) begin
                                state_d = ST_ALARM;
                            end
                        end
                    end
                    default: begin
                        // ALARM is sticky until a clear or a reset.
                        // Only prev and expected keep tracking.
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_HUNT;
            prev_q         <= 3'd0;
            prev_vld_q     <= 1'b0;
            good_run_q     <= 8'd0;
            bad_run_q      <= 8'd0;
            err_count_q    <= 8'd0;
            period_count_q <= 16'd0;
            seq_err_q      <= 1'b0;
            expected_q     <= 3'd0;
        end else begin
            state_q        <= state_d;
            prev_q         <= prev_d;
            prev_vld_q     <= prev_vld_d;
            good_run_q     <= good_run_d;
            bad_run_q      <= bad_run_d;
            err_count_q    <= err_count_d;
            period_count_q <= period_count_d;
            seq_err_q      <= seq_err_d;
            expected_q     <= expected_d;
        end
    end

    assign seq_err      = seq_err_q;
    assign locked       = (state_q == ST_LOCKED);
    assign alarm        = (state_q == ST_ALARM);
    assign expected     = expected_q;
    assign err_count    = err_count_q;
    assign period_count = period_count_q;

endmodule

// File: tb/tb_count_seq_checker.sv
module tb_count_seq_checker;

    localparam int MAXV = 4;
    localparam int LOCKN = 2;
    localparam int ERRN = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  cnt_in = 3'd0;
    logic        cnt_valid = 1'b0;
    logic        clr_stats = 1'b0;
    logic        seq_err;
    logic        locked;
    logic        alarm;
    logic [2:0]  expected;
    logic [7:0]  err_count;
    logic [15:0] period_count;

    int total = 0;
    int bad = 0;

    // Behavioural reference: mode is a word, runs and counters are ints.
    string m_mode = "HUNT";
    bit    m_has_prev = 0;
    int    m_prev = 0;
    int    m_good = 0;
    int    m_bad = 0;
    int    m_err = 0;
    int    m_per = 0;
    bit    m_seqerr = 0;

    count_seq_checker #(.MAX_VAL(MAXV), .LOCK_COUNT(LOCKN), .ERR_LIMIT(ERRN)) dut (
        .clk(clk),
        .reset(reset),
        .cnt_in(cnt_in),
        .cnt_valid(cnt_valid),
        .clr_stats(clr_stats),
        .seq_err(seq_err),
        .locked(locked),
        .alarm(alarm),
        .expected(expected),
        .err_count(err_count),
        .period_count(period_count)
    );

    always #5 clk = ~clk;

    function automatic int succ(int v);
        return (v + 1) % (MAXV + 1);
    endfunction

    function automatic int model_expected();
        if (!m_has_prev || m_prev > MAXV) return 0;
        return succ(m_prev);
    endfunction

    task automatic model_edge(bit r, bit c, bit v, int x);
        bit ok;
        m_seqerr = 0;
        if (r) begin
            m_mode = "HUNT"; m_has_prev = 0; m_prev = 0;
            m_good = 0; m_bad = 0; m_err = 0; m_per = 0;
        end else if (c) begin
            m_mode = "HUNT"; m_has_prev = 0;
            m_good = 0; m_bad = 0; m_err = 0; m_per = 0;
        end else if (v) begin
            if (m_has_prev) begin
                ok = (x <= MAXV) && (m_prev <= MAXV) && (x == succ(m_prev));
                if (m_mode == "HUNT") begin
                    m_good = ok ? m_good + 1 : 0;
                    if (m_good >= LOCKN) begin
                        m_mode = "LOCKED"; m_good = 0; m_bad = 0;
                    end
                end else if (m_mode == "LOCKED") begin
                    if (ok) begin
                        m_bad = 0;
                        if (m_prev == MAXV && x == 0) m_per = (m_per + 1) % 65536;
                    end else begin
                        m_seqerr = 1;
                        m_err = (m_err < 255) ? m_err + 1 : 255;
                        m_bad++;
                        if (m_bad >= ERRN) m_mode = "ALARM";
                    end
                end
            end
            m_prev = x;
            m_has_prev = 1;
        end
    endtask

    task automatic chk(string tag, int obs, int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(string tag);
        chk({tag, ".seq_err"}, int'(seq_err), int'(m_seqerr));
        chk({tag, ".locked"}, int'(locked), (m_mode == "LOCKED") ? 1 : 0);
        chk({tag, ".alarm"}, int'(alarm), (m_mode == "ALARM") ? 1 : 0);
        chk({tag, ".expected"}, int'(expected), model_expected());
        chk({tag, ".err_count"}, int'(err_count), m_err);
        chk({tag, ".period_count"}, int'(period_count), m_per);
    endtask

    // One clock: drive, edge, update model, sample 1 time unit later.
    task automatic cyc(string tag, bit r, bit c, bit v, int x, bit verbose);
        reset = r; clr_stats = c; cnt_valid = v; cnt_in = 3'(x);
        @(posedge clk);
        model_edge(r, c, v, x);
        #1;
        check_model(tag);
        if (verbose)
            $display("%s rst=%0d clr=%0d vld=%0d in=%0d -> seq_err=%0d locked=%0d alarm=%0d exp=%0d err=%0d per=%0d",
                     tag, r, c, v, x, seq_err, locked, alarm, expected, err_count, period_count);
    endtask

    task automatic sample(string tag, int x);
        cyc(tag, 0, 0, 1, x, 1);
    endtask

    int seq031[7] = '{4, 0, 1, 2, 3, 4, 0};
    int p;

    initial begin
        // reset state
        cyc("reset", 1, 0, 0, 0, 1);
        cyc("reset", 1, 0, 1, 3, 1);
        chk("reset.locked_const", int'(locked), 0);
        chk("reset.expected_const", int'(expected), 0);

        // lock after 1,2,3
        sample("lock", 1);
        sample("lock", 2);
        chk("lock.not_yet", int'(locked), 0);
        sample("lock", 3);
        chk("lock.locked_const", int'(locked), 1);
        chk("lock.expected_const", int'(expected), 4);

        // two full periods
        foreach (seq031[i]) sample("period", seq031[i]);
        chk("period.count_const", int'(period_count), 2);
        chk("period.err_const", int'(err_count), 0);

        // illegal value 7 after prev=2, then 0 is also a mismatch
        sample("illegal", 1);
        sample("illegal", 2);
        sample("illegal", 7);
        chk("illegal.seq_err_const", int'(seq_err), 1);
        chk("illegal.err_const", int'(err_count), 1);
        chk("illegal.expected_const", int'(expected), 0);
        cyc("illegal_idle", 0, 0, 0, 5, 1);
        chk("illegal.pulse_gone", int'(seq_err), 0);
        sample("illegal", 0);
        chk("illegal.after7_err", int'(err_count), 2);

        // three mismatches in a row -> alarm
        cyc("reset2", 1, 0, 0, 0, 1);
        sample("relock", 0);
        sample("relock", 1);
        sample("relock", 2);
        sample("burst", 2);
        sample("burst", 2);
        sample("burst", 2);
        chk("burst.alarm_const", int'(alarm), 1);
        chk("burst.locked_const", int'(locked), 0);
        chk("burst.err_const", int'(err_count), 3);
        sample("alarm_hold", 3);
        sample("alarm_hold", 7);
        sample("alarm_hold", 1);
        chk("alarm_hold.err_const", int'(err_count), 3);
        chk("alarm_hold.expected_const", int'(expected), 2);

        // clear with a simultaneous sample
        cyc("clear", 0, 1, 1, 3, 1);
        chk("clear.alarm_const", int'(alarm), 0);
        chk("clear.expected_const", int'(expected), 0);
        chk("clear.err_const", int'(err_count), 0);

        // saturation: skip-one mismatch followed by a match, 256 times
        cyc("reset3", 1, 0, 0, 0, 1);
        sample("sat_lock", 0);
        sample("sat_lock", 1);
        sample("sat_lock", 2);
        p = 2;
        for (int i = 0; i < 256; i++) begin
            p = (p + 2) % (MAXV + 1);
            cyc("sat_miss", 0, 0, 1, p, 0);
            if (i < 255) begin
                p = succ(p);
                cyc("sat_match", 0, 0, 1, p, 0);
            end
        end
        chk("sat.err_const", int'(err_count), 255);
        chk("sat.locked_const", int'(locked), 1);
        cyc("sat_reset", 1, 0, 1, succ(p), 1);
        chk("sat_reset.err_const", int'(err_count), 0);
        chk("sat_reset.locked_const", int'(locked), 0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit r, c, v;
            int x;
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 49) == 0);
            v = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 7 && m_has_prev && m_prev <= MAXV)
                x = succ(m_prev);
            else
                x = $urandom_range(0, 7);
            cyc("rand", r, c, v, x, 0);
        end
        $display("random phase: %0d cycles checked", 3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
